// File: rtl/spi_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_queue
// Purpose  : Byte queue that feeds an SPI master and sequences frames on cs.
//            Optional launch watchdog enabled by macro SPI_TXQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module spi_tx_queue #(
    parameter int DEPTH          = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_cpol,
    input  logic                     in_cpha,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     cs,
    output logic                     start,
    output logic [7:0]               p_dat,
    output logic                     cpol,
    output logic                     cpha,
    output logic                     busy,
    output logic                     tx_done,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] c_depth    = LW'(DEPTH);
    localparam logic [7:0]    c_gap_last = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LAUNCH   = 2'd1,
        S_WAIT_END = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [9:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic [7:0]      r_gap_cnt;
    logic [7:0]      r_p_dat;
    logic            r_cpol;
    logic            r_cpha;
    logic            r_tx_done;
    logic            w_push;
    logic            w_pop;
    logic            w_done;

`ifdef SPI_TXQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_to_last = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]   r_to_cnt;
    logic            r_err;
    logic            w_timeout;
`endif

    assign in_ready = (r_level < c_depth);
    assign w_push   = in_valid && in_ready;
    assign level    = r_level;
    assign p_dat    = r_p_dat;
    assign cpol     = r_cpol;
    assign cpha     = r_cpha;
    assign tx_done  = r_tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A pop only ever happens on the IDLE->LAUNCH transition.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        start        = 1'b0;
        busy         = (r_state != S_IDLE);
`ifdef SPI_TXQ_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if ((r_level != '0) && cs) begin
                    w_state_next = S_LAUNCH;
                    w_pop        = 1'b1;
                end
            end
            S_LAUNCH: begin
                start = 1'b1;
                if (!cs) begin
                    w_state_next = S_WAIT_END;
                end
`ifdef SPI_TXQ_TIMEOUT_EN
                else if (r_to_cnt == c_to_last) begin
                    w_state_next = S_IDLE;
                    w_timeout    = 1'b1;
                end
`endif
            end
            S_WAIT_END: begin
                if (cs) begin
                    w_done       = 1'b1;
                    w_state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_cpol, in_cpha, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_p_dat   <= 8'h00;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_tx_done <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_tx_done <= w_done;
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 8'd1 : 8'd0;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + AW'(1);
                r_p_dat <= r_mem[r_rptr][7:0];
                r_cpol  <= r_mem[r_rptr][9];
                r_cpha  <= r_mem[r_rptr][8];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef SPI_TXQ_TIMEOUT_EN
    // Watchdog counts cycles spent in LAUNCH; the popped byte is dropped on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_LAUNCH) ? r_to_cnt + TW'(1) : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_queue.sv
`default_nettype none
// Testbench for spi_tx_queue: scoreboard of launched entries plus directed timing checks.
module tb_spi_tx_queue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_cpol = 1'b0;
    logic       in_cpha = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       cs;
    logic       start;
    logic [7:0] p_dat;
    logic       cpol;
    logic       cpha;
    logic       busy;
    logic       tx_done;
    logic [3:0] level;
    logic       err;

    logic       m_en = 1'b0;
    logic       cs_m = 1'b1;
    logic       cs_host = 1'b1;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         last_done = -1;
    bit         gap_chk = 1'b0;
    logic       prev_start = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cs = m_en ? cs_m : cs_host;

    spi_tx_queue #(
        .DEPTH(DEPTH),
        .GAP_CYCLES(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_cpol(in_cpol),
        .in_cpha(in_cpha),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cs(cs),
        .start(start),
        .p_dat(p_dat),
        .cpol(cpol),
        .cpha(cpha),
        .busy(busy),
        .tx_done(tx_done),
        .level(level),
        .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; the handshake happens at the next edge.
    task automatic push(input logic [7:0] d, input logic pol, input logic pha, input bit accept);
        in_data  = d;
        in_cpol  = pol;
        in_cpha  = pha;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_at_push", in_ready, accept);
        if (accept) exp_q.push_back({pol, pha, d});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Master model: pulls cs low 3 cycles after seeing start, releases it 4 cycles later.
    always begin
        @(negedge clk);
        if (m_en && start) begin
            repeat (3) @(posedge clk);
            #1 cs_m = 1'b0;
            repeat (4) @(posedge clk);
            #1 cs_m = 1'b1;
        end
    end

    // Monitor: each new launch must present the next expected entry.
    always @(negedge clk) begin
        if (start && !prev_start) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got p_dat=0x%0h expected no launch", p_dat);
            end else begin
                e = exp_q.pop_front();
                check("launch_entry", {22'd0, cpol, cpha, p_dat}, {22'd0, e});
            end
            if (gap_chk && last_done >= 0) check("gap_spacing", cyc - last_done, 5);
        end
        if (tx_done) begin
            done_cnt++;
            last_done = cyc;
        end
        prev_start = start;
    end

    initial begin
        int base;
        int n;

        // Reset values
        tick(2);
        @(negedge clk);
        check("rst_start", start, 0);
        check("rst_p_dat", p_dat, 8'h00);
        check("rst_mode", {cpol, cpha}, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_level", level, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        // Single byte with responsive master
        m_en = 1'b1;
        base = done_cnt;
        push(8'hA5, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("start_before_pop", start, 0);
        check("level_after_push", level, 1);
        @(negedge clk);
        check("start_at_k1", start, 1);
        check("level_after_pop", level, 0);
        check("busy_in_launch", busy, 1);
        @(posedge clk);
        #1;
        tick(30);
        check("single_done_count", done_cnt - base, 1);
        check("single_level_end", level, 0);
        check("single_busy_end", busy, 0);

        // Fill with master stalled
        m_en = 1'b0;
        cs_host = 1'b1;
        base = done_cnt;
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] b;
            b = 8'(i);
            push(b, b[0], b[1], 1'b1);
        end
        @(negedge clk);
        check("fill_level7", level, 7);
        @(posedge clk);
        #1;
        push(8'h09, 1'b1, 1'b0, 1'b1);
        push(8'h0A, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("fill_level8", level, 8);
        check("fill_not_ready", in_ready, 0);
        @(posedge clk);
        #1 m_en = 1'b1;
        tick(200);
        check("drain_done_count", done_cnt - base, 9);
        check("drain_level", level, 0);

        // Back-to-back frames and gap spacing
        base = done_cnt;
        last_done = -1;
        gap_chk = 1'b1;
        push(8'h11, 1'b0, 1'b1, 1'b1);
        push(8'h22, 1'b1, 1'b1, 1'b1);
        push(8'h33, 1'b0, 1'b0, 1'b1);
        tick(60);
        gap_chk = 1'b0;
        check("b2b_done_count", done_cnt - base, 3);

        // Foreign transfer holds cs low
        m_en = 1'b0;
        cs_host = 1'b0;
        base = done_cnt;
        push(8'h77, 1'b1, 1'b1, 1'b1);
        repeat (6) begin
            @(negedge clk);
            check("start_blocked", start, 0);
        end
        @(posedge clk);
        #1 cs_host = 1'b1;
        @(negedge clk);
        check("start_cs_just_high", start, 0);
        @(negedge clk);
        check("start_after_cs", start, 1);
        @(posedge clk);
        #1 m_en = 1'b1;
        tick(20);
        check("cs_block_done", done_cnt - base, 1);

        // Asynchronous reset during WAIT_END with 3 bytes queued
        m_en = 1'b0;
        cs_host = 1'b1;
        base = done_cnt;
        push(8'hC1, 1'b1, 1'b1, 1'b1);
        push(8'hC2, 1'b0, 1'b1, 1'b1);
        push(8'hC3, 1'b1, 1'b0, 1'b1);
        push(8'hC4, 1'b0, 1'b0, 1'b1);
        tick(2);
        cs_host = 1'b0;
        tick(2);
        @(negedge clk);
        check("wait_end_busy", busy, 1);
        check("wait_end_start", start, 0);
        check("wait_end_level", level, 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_start", start, 0);
        check("arst_busy", busy, 0);
        check("arst_level", level, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_p_dat", p_dat, 8'h00);
        check("arst_mode", {cpol, cpha}, 2'b00);
        check("arst_tx_done", tx_done, 0);
        exp_q.delete();
        cs_host = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("arst_no_done", done_cnt - base, 0);
        check("arst_level_after", level, 0);

        // Launch with cs never falling
        base = done_cnt;
        m_en = 1'b0;
        cs_host = 1'b1;
        push(8'h5A, 1'b0, 1'b1, 1'b1);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (start) n++;
        end
`ifdef SPI_TXQ_TIMEOUT_EN
        check("timeout_start_cycles", n, 16);
        check("timeout_err", err, 1);
        check("timeout_no_done", done_cnt - base, 0);
        check("timeout_busy", busy, 0);
`else
        check("launch_hold_cycles", n, 39);
        check("launch_hold_err", err, 0);
        @(posedge clk);
        #1 m_en = 1'b1;
        tick(20);
        check("launch_hold_done", done_cnt - base, 1);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end

endmodule
`default_nettype wire
